// File: rtl/tc_merge_ctrl.sv
// ----------------------------------------------------------------------------
// tc_merge_ctrl
//
// Purpose:
//   Sequences one K-tile accumulation job through a merge tree that has a fixed
//   issue-to-output latency. Each accepted beat is driven into the tree. The
//   first beat of a job takes a zero psum. Every later beat takes the tree's
//   own output as feedback, so no beat may issue while a previous beat is
//   still in flight. Each tree output is tagged either as an intermediate
//   partial sum or as the final result.
//
// Parameters:
//   LATENCY  merge-tree issue-to-output latency in cycles (only 3 is legal)
//   DW_CNT   width of the K-tile count and of k_idx_o
//
// Ports:
//   clk_i          single clock; all state changes on its rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        start one accumulation job (ignored while busy_o = 1)
//   cfg_num_k_i    number of K-tile beats in the job
//   mult_valid_i   upstream presents one beat of products
//   mult_ready_o   controller accepts the beat this cycle
//   mt_in_valid_o  beat is driven into the merge tree this cycle
//   mt_psum_sel_o  psum mux select: 0 = zero, 1 = merge-tree feedback
//   acc_valid_o    merge-tree output holds an intermediate partial sum
//   res_valid_o    merge-tree output holds the final result
//   busy_o         job active (ISSUE or DRAIN)
//   done_o         one-cycle completion pulse
//   k_idx_o        index of the next beat to issue
//
// Optional feature (macro TC_MERGE_CTRL_PERF_EN):
//   perf_beat_cnt_o   saturating count of fired beats
//   perf_stall_cnt_o  saturating count of ISSUE cycles with mult_valid_i = 1
//                     and mult_ready_o = 0
// ----------------------------------------------------------------------------
module tc_merge_ctrl #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DW_CNT  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DW_CNT-1:0] cfg_num_k_i,
    input  logic              mult_valid_i,
    output logic              mult_ready_o,
    output logic              mt_in_valid_o,
    output logic              mt_psum_sel_o,
    output logic              acc_valid_o,
    output logic              res_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DW_CNT-1:0] k_idx_o
`ifdef TC_MERGE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_beat_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    // The hazard window and the valid pipeline below are sized for a 3-cycle tree.
    if (LATENCY != 3) begin : g_bad_latency
        $error("tc_merge_ctrl: LATENCY must be 3");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [DW_CNT-1:0]   k_idx_q, k_idx_d;
    logic [DW_CNT-1:0]   num_k_q, num_k_d;
    logic [LATENCY-1:0]  vld_q, vld_d;    // one bit per in-flight beat, oldest at MSB
    logic [LATENCY-1:0]  last_q, last_d;  // marks the in-flight beat that is the job's last
    logic                zero_done_q, zero_done_d;

    logic                fire;
    logic                last_beat;
    logic                hazard;
    logic                start_job;
    logic                start_empty;
    logic                out_vld;
    logic                out_last;

    // A beat issued in any of the last LATENCY-1 cycles has not yet produced the
    // feedback psum the next beat needs.
    assign hazard      = |vld_q[LATENCY-2:0];
    assign fire        = mult_valid_i & mult_ready_o;
    assign last_beat   = (k_idx_q == (num_k_q - DW_CNT'(1)));
    assign start_job   = (state_q == StIdle) & start_i & (cfg_num_k_i != '0);
    assign start_empty = (state_q == StIdle) & start_i & (cfg_num_k_i == '0);
    assign out_vld     = vld_q[LATENCY-1];
    assign out_last    = last_q[LATENCY-1];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_job) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (fire && last_beat) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Only the last beat can still be in flight here.
                if (out_vld) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mult_ready_o  = 1'b0;
        busy_o        = 1'b0;
        done_o        = zero_done_q;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
            end
            StIssue: begin
                busy_o       = 1'b1;
                mult_ready_o = ~hazard;
            end
            StDrain: begin
                busy_o = 1'b1;
                done_o = out_vld & out_last;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign mt_in_valid_o = fire;
    assign mt_psum_sel_o = (k_idx_q != '0);
    assign acc_valid_o   = out_vld & ~out_last;
    assign res_valid_o   = out_vld & out_last;
    assign k_idx_o       = k_idx_q;

    // ------------------------------------------------------------------------
    // Job counters and the in-flight pipeline
    // ------------------------------------------------------------------------
    always_comb begin
        k_idx_d     = k_idx_q;
        num_k_d     = num_k_q;
        zero_done_d = start_empty;
        vld_d       = {vld_q[LATENCY-2:0], fire};
        last_d      = {last_q[LATENCY-2:0], fire & last_beat};
        if (start_job) begin
            k_idx_d = '0;
            num_k_d = cfg_num_k_i;
        end else if (fire) begin
            k_idx_d = k_idx_q + DW_CNT'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_idx_q     <= '0;
            num_k_q     <= '0;
            zero_done_q <= 1'b0;
            vld_q       <= '0;
            last_q      <= '0;
        end else begin
            k_idx_q     <= k_idx_d;
            num_k_q     <= num_k_d;
            zero_done_q <= zero_done_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

`ifdef TC_MERGE_CTRL_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------------
    logic [31:0] perf_beat_q, perf_beat_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    assign stall = (state_q == StIssue) & mult_valid_i & ~mult_ready_o;

    always_comb begin
        perf_beat_d  = perf_beat_q;
        perf_stall_d = perf_stall_q;
        if (fire && (perf_beat_q != '1)) begin
            perf_beat_d = perf_beat_q + 32'd1;
        end
        if (stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_beat_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_beat_q  <= perf_beat_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_beat_cnt_o  = perf_beat_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
